// File: rtl/fcvt_wb_stage.sv
// FCVT.W[U].S result stage: negation, saturation and NV/NX flags on the converter's magnitude.
// Latency 1 cycle; throughput 1/cycle with the 2-entry (out + skid) FIFO.
// Backpressure: in_ready = !skid_valid (SKID_EN=1) or !out_valid || out_ready (SKID_EN=0).
// Optional sticky flag accumulator: define FCVT_WB_STICKY_FFLAGS_EN.
module fcvt_wb_stage #(
    parameter int RD_W    = 5,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     float_in,
    input  logic            is_signed,
    input  logic [2:0]      rm,
    input  logic [31:0]     mag_in,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [4:0]      out_fflags,
    output logic [RD_W-1:0] out_rd
`ifdef FCVT_WB_STICKY_FFLAGS_EN
    ,
    output logic [4:0]      fflags_acc,
    input  logic            fflags_clr
`endif
);

    typedef struct packed {
        logic [31:0]     result;
        logic [4:0]      fflags;
        logic [RD_W-1:0] rd;
    } entry_t;

    entry_t      out_q;
    entry_t      skid_q;
    entry_t      new_e;
    logic        skid_valid;
    logic        in_fire;

    logic        sgn;
    logic [7:0]  ex;
    logic [22:0] man;
    logic        nan;
    logic [7:0]  sh;
    logic [22:0] mask;
    logic        nx_raw;
    logic        nv;
    logic [31:0] res;

    // Rounding mode is already folded into mag_in by the converter.
    logic unused_rm;
    assign unused_rm = ^rm;

    always_comb begin
        sgn    = float_in[31];
        ex     = float_in[30:23];
        man    = float_in[22:0];
        nan    = (ex == 8'hFF) && (man != 23'd0);
        // sh = number of fraction bits below the binary point when 127 <= ex < 150
        sh     = 8'd150 - ex;
        mask   = 23'((24'd1 << sh) - 24'd1);
        nx_raw = 1'b0;
        if (ex < 8'd127)
            nx_raw = (ex != 8'd0) || (man != 23'd0);
        else if (ex < 8'd150)
            nx_raw = |(man & mask);

        nv  = 1'b0;
        res = mag_in;
        if (!is_signed) begin
            if (nan || (!sgn && mag_in == 32'hFFFF_FFFF && ex >= 8'h9F)) begin
                res = 32'hFFFF_FFFF;
                nv  = 1'b1;
            end else if (sgn) begin
                res = 32'd0;
                nv  = (mag_in != 32'd0);
            end
        end else begin
            if (nan || (!sgn && (mag_in > 32'h7FFF_FFFF || ex >= 8'h9E))) begin
                res = 32'h7FFF_FFFF;
                nv  = 1'b1;
            end else if (sgn && (mag_in > 32'h8000_0000 || ex > 8'h9E)) begin
                res = 32'h8000_0000;
                nv  = 1'b1;
            end else if (sgn) begin
                res = ~mag_in + 32'd1;
            end
        end

        new_e.result = res;
        new_e.fflags = {nv, 3'b000, nx_raw & ~nv};
        new_e.rd     = rd_in;
    end

    assign in_ready = SKID_EN ? !skid_valid : (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (!out_valid || out_ready) begin
                // Skid entry is older than any new input; in_ready is low while it is held.
                if (skid_valid) begin
                    out_q      <= skid_q;
                    skid_valid <= 1'b0;
                    out_valid  <= 1'b1;
                end else if (in_fire) begin
                    out_q     <= new_e;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (in_fire && SKID_EN) begin
                skid_q     <= new_e;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_result = out_q.result;
    assign out_fflags = out_q.fflags;
    assign out_rd     = out_q.rd;

`ifdef FCVT_WB_STICKY_FFLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fflags_acc <= 5'd0;
        else if (fflags_clr)
            fflags_acc <= 5'd0;
        else if (out_valid && out_ready)
            fflags_acc <= fflags_acc | out_q.fflags;
    end
`endif

endmodule

// File: tb/tb_fcvt_wb_stage.sv
// Bench for fcvt_wb_stage: directed vector table, backpressure/flush sequences, randomized
// traffic against a queue-based reference of the conversion rules.
module tb_fcvt_wb_stage;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     float_in;
    logic            is_signed;
    logic [2:0]      rm;
    logic [31:0]     mag_in;
    logic [RD_W-1:0] rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [4:0]      out_fflags;
    logic [RD_W-1:0] out_rd;
`ifdef FCVT_WB_STICKY_FFLAGS_EN
    logic [4:0]      fflags_acc;
    logic            fflags_clr;
`endif

    fcvt_wb_stage #(.RD_W(RD_W), .SKID_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .float_in(float_in), .is_signed(is_signed), .rm(rm),
        .mag_in(mag_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_fflags(out_fflags), .out_rd(out_rd)
`ifdef FCVT_WB_STICKY_FFLAGS_EN
        , .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    typedef struct {
        logic [31:0]     result;
        logic [4:0]      fflags;
        logic [RD_W-1:0] rd;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] f;
        logic        sg;
        logic [31:0] mag;
        logic [31:0] res;
        logic [4:0]  flags;
    } vec_t;

    logic            prev_held = 1'b0;
    logic [31:0]     prev_res;
    logic [4:0]      prev_flags;
    logic [RD_W-1:0] prev_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: conversion rules evaluated with wide signed integers.
    function automatic logic [36:0] model(input logic [31:0] f, input logic sg, input logic [31:0] mag);
        logic   s   = f[31];
        int     e   = int'(f[30:23]);
        longint mm  = longint'(f[22:0]);
        logic   isnan = (e == 255) && (mm != 0);
        logic   nx  = 1'b0;
        logic   nv  = 1'b0;
        longint v;
        logic [31:0] r;
        if (e < 127) nx = (e != 0) || (mm != 0);
        else if (e < 150) nx = ((mm + (longint'(1) << 23)) % (longint'(1) << (150 - e))) != 0;
        if (!sg) begin
            if (isnan || (!s && mag == 32'hFFFF_FFFF && e >= 159)) begin r = 32'hFFFF_FFFF; nv = 1'b1; end
            else if (s) begin r = 32'd0; nv = (mag != 0); end
            else r = mag;
        end else begin
            v = s ? -longint'(mag) : longint'(mag);
            if (isnan) begin r = 32'h7FFF_FFFF; nv = 1'b1; end
            else if (!s && (v > 64'sd2147483647 || e >= 158)) begin r = 32'h7FFF_FFFF; nv = 1'b1; end
            else if (s && (v < -64'sd2147483648 || e > 158)) begin r = 32'h8000_0000; nv = 1'b1; end
            else r = v[31:0];
        end
        return {r, nv, 3'b000, nx && !nv};
    endfunction

    // One clock: sample/score at negedge, then advance to just after the next posedge.
    task automatic cycle();
        logic [36:0] m;
        exp_t        e;
        @(negedge clk);
        if (prev_held)
            check("hold_stable", {31'd0, out_valid, out_result, out_fflags, out_rd},
                  {31'd0, 1'b1, prev_res, prev_flags, prev_rd});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {32'd0, out_result}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_entry", {22'd0, out_result, out_fflags, out_rd}, {22'd0, e.result, e.fflags, e.rd});
            end
            pops++;
        end
        if (in_valid && in_ready && !flush) begin
            m = model(float_in, is_signed, mag_in);
            e.result = m[36:5];
            e.fflags = m[4:0];
            e.rd     = rd_in;
            sb.push_back(e);
        end
        if (flush) sb.delete();
        prev_held  = out_valid && !out_ready && !flush;
        prev_res   = out_result;
        prev_flags = out_fflags;
        prev_rd    = out_rd;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] f, input logic sg, input logic [31:0] mag, input logic [RD_W-1:0] rd);
        float_in  = f;
        is_signed = sg;
        mag_in    = mag;
        rd_in     = rd;
        rm        = 3'($urandom_range(0, 4));
    endtask

    task automatic drive_random(input logic [RD_W-1:0] rd);
        int          e = ($urandom % 16 == 0) ? 255 : int'($urandom_range(100, 169));
        logic [22:0] m = ($urandom % 4 == 0) ? 23'd0 : 23'($urandom);
        longint      sig = longint'({1'b1, m});
        longint      v;
        logic [31:0] mag;
        if (e < 127) v = 0;
        else if (e >= 159) v = 64'hFFFF_FFFF;
        else if (e >= 150) v = sig << (e - 150);
        else v = sig >> (150 - e);
        v = v + longint'($urandom % 2);
        if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
        case ($urandom % 8)
            0: mag = $urandom;
            1: mag = 32'h8000_0000;
            2: mag = 32'hFFFF_FFFF;
            default: mag = v[31:0];
        endcase
        drive({1'($urandom), 8'(e), m}, 1'($urandom), mag, rd);
    endtask

    vec_t vecs[15];

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] a_res;
        int          pops0;
        logic        acc;

        vecs[0]  = '{32'hC020_0000, 1'b1, 32'd2,          32'hFFFF_FFFE, 5'b00001};
        vecs[1]  = '{32'hBF80_0000, 1'b0, 32'd1,          32'h0000_0000, 5'b10000};
        vecs[2]  = '{32'h7FC0_0000, 1'b1, 32'd0,          32'h7FFF_FFFF, 5'b10000};
        vecs[3]  = '{32'hCF00_0000, 1'b1, 32'h8000_0000,  32'h8000_0000, 5'b00000};
        vecs[4]  = '{32'h4F00_0000, 1'b1, 32'h8000_0000,  32'h7FFF_FFFF, 5'b10000};
        vecs[5]  = '{32'h3F00_0000, 1'b0, 32'd0,          32'h0000_0000, 5'b00001};
        vecs[6]  = '{32'h0000_0000, 1'b1, 32'd0,          32'h0000_0000, 5'b00000};
        vecs[7]  = '{32'h8000_0000, 1'b0, 32'd0,          32'h0000_0000, 5'b00000};
        vecs[8]  = '{32'hBF00_0000, 1'b0, 32'd0,          32'h0000_0000, 5'b00001};
        vecs[9]  = '{32'h4F80_0000, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'b10000};
        vecs[10] = '{32'h4040_0000, 1'b1, 32'd3,          32'h0000_0003, 5'b00000};
        vecs[11] = '{32'h3FC0_0000, 1'b0, 32'd2,          32'h0000_0002, 5'b00001};
        vecs[12] = '{32'hFF80_0000, 1'b1, 32'hFFFF_FFFF,  32'h8000_0000, 5'b10000};
        vecs[13] = '{32'h7F80_0000, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'b10000};
        vecs[14] = '{32'hC040_0000, 1'b1, 32'd3,          32'hFFFF_FFFD, 5'b00000};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(32'd0, 1'b0, 32'd0, '0);
`ifdef FCVT_WB_STICKY_FFLAGS_EN
        fflags_clr = 1'b0;
`endif
        @(posedge clk); #1;
        check("reset_held_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_held_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_reset_result", {32'd0, out_result}, 64'd0);
        check("post_reset_fflags", {59'd0, out_fflags}, 64'd0);

        // Directed vectors, one at a time with writeback always ready.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].f, vecs[i].sg, vecs[i].mag, RD_W'(i));
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_result", i), {32'd0, out_result}, {32'd0, vecs[i].res});
            check($sformatf("vec%0d_fflags", i), {59'd0, out_fflags}, {59'd0, vecs[i].flags});
            check($sformatf("vec%0d_rd", i), {59'd0, out_rd}, 64'(i));
            cycle();
        end

        // Backpressure: A on out, B in skid, C blocked, then drain in order.
        out_ready = 1'b0;
        drive(32'h4040_0000, 1'b1, 32'd3, 5'd1); in_valid = 1'b1; cycle();
        a_res = 32'd3;
        drive(32'hC020_0000, 1'b1, 32'd2, 5'd2); cycle();
        drive(32'h40A0_0000, 1'b0, 32'd5, 5'd3); cycle();
        check("bp_in_ready_blocked", {63'd0, in_ready}, 64'd0);
        check("bp_a_held", {31'd0, out_valid, out_result}, {31'd0, 1'b1, a_res});
        pops0 = pops;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            acc = in_valid && in_ready;
            cycle();
            if (acc) in_valid = 1'b0;
        end
        check("bp_three_emerged", 64'(pops - pops0), 64'd3);
        check("bp_drained_queue", 64'(sb.size()), 64'd0);

        // Flush with two entries held; a same-cycle input is dropped.
        out_ready = 1'b0;
        drive(32'h3FC0_0000, 1'b0, 32'd2, 5'd4); in_valid = 1'b1; cycle();
        drive(32'hBF80_0000, 1'b0, 32'd1, 5'd5); cycle();
        check("flush_pre_in_ready", {63'd0, in_ready}, 64'd0);
        drive(32'h4040_0000, 1'b1, 32'd3, 5'd6); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        cycle();
        check("flush_no_ghost", {63'd0, out_valid}, 64'd0);

`ifdef FCVT_WB_STICKY_FFLAGS_EN
        fflags_clr = 1'b1; cycle(); fflags_clr = 1'b0;
        drive(32'h3FC0_0000, 1'b0, 32'd2, 5'd7); in_valid = 1'b1; cycle();
        drive(32'hBF80_0000, 1'b0, 32'd1, 5'd8); cycle();
        in_valid = 1'b0; cycle(); cycle();
        check("sticky_or", {59'd0, fflags_acc}, {59'd0, 5'b10001});
        fflags_clr = 1'b1; cycle(); fflags_clr = 1'b0;
        check("sticky_clr", {59'd0, fflags_acc}, 64'd0);
`endif

        // Randomized traffic against the reference queue.
        for (int n = 0; n < 3000; n++) begin
            drive_random(RD_W'($urandom));
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && (out_valid || sb.size() != 0); k++) cycle();
        check("final_drain", {31'd0, out_valid, 32'(sb.size())}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
